// File: rtl/chequeo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chequeo_pkg
// Brief    : Shared FSM state encoding and counter width for chequeo_dma_rr.
// Revision : 1.0 - initial release
// ============================================================================
package chequeo_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RECIBIR   = 3'd1,
    SOLICITAR = 3'd2,
    ENVIAR    = 3'd3,
    LIBERAR   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/chequeo_dma_rr_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick of the first pending channel
//            after ptr, wrapping modulo N_CH.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         pend,
  input  logic [$clog2(N_CH)-1:0] ptr,
  output logic                    grant_valid,
  output logic [$clog2(N_CH)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(N_CH);

  // w_cand[k] is the channel at search distance k+1 from ptr
  logic [IDX_W-1:0] w_cand [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_cand
    assign w_cand[k] = IDX_W'((int'(ptr) + k + 1) % N_CH);
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!grant_valid && pend[w_cand[k]]) begin
        grant_valid = 1'b1;
        grant_idx   = w_cand[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/chequeo_dma_rr.sv
`default_nettype none
// ============================================================================
// Module   : chequeo_dma_rr
// Brief    : Round-robin multi-channel DMA bus-request controller.
//            Optional grant timeout enabled by defining CHEQUEO_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module chequeo_dma_rr
  import chequeo_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         estado_in,
  input  logic                    check_in,
  output logic                    check_out,
  output logic                    sel,
  output logic [$clog2(N_CH)-1:0] ch_sel,
  output logic [N_CH-1:0]         recibir,
  output logic [N_CH-1:0]         enviar,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int IDX_W = $clog2(N_CH);

  state_t           r_state;
  logic [N_CH-1:0]  r_estado_q;
  logic [N_CH-1:0]  r_pend;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_burst;

  logic             w_grant_valid;
  logic [IDX_W-1:0] w_grant_idx;
  logic [N_CH-1:0]  w_grant_oh;
  logic [N_CH-1:0]  w_sel_oh;
  logic [N_CH-1:0]  w_set;
  logic [N_CH-1:0]  w_clr;
  logic             w_abort;
  logic             w_timeout;
  logic             w_requeue;

`ifdef CHEQUEO_TIMEOUT_EN
  logic [CNT_W-1:0] r_wait;
  assign w_timeout = (r_state == SOLICITAR) && !check_in &&
                     (r_wait == CNT_W'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
`endif

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .pend        (r_pend),
    .ptr         (r_ptr),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  assign w_grant_oh = {{(N_CH-1){1'b0}}, 1'b1} << w_grant_idx;
  assign w_sel_oh   = {{(N_CH-1){1'b0}}, 1'b1} << ch_sel;
  assign w_abort    = (r_state == ENVIAR) && !check_in;
  assign w_requeue  = w_abort || w_timeout;

  // A re-queued channel sits behind the others because ptr already points at it
  assign w_clr = (r_state == IDLE && w_grant_valid) ? w_grant_oh : '0;
  assign w_set = (estado_in & ~r_estado_q) | (w_requeue ? w_sel_oh : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado_q <= '0;
      r_pend     <= '0;
    end else begin
      r_estado_q <= estado_in;
      r_pend     <= (r_pend & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= IDX_W'(N_CH - 1);
      ch_sel      <= '0;
      r_burst     <= '0;
      check_out   <= 1'b0;
      sel         <= 1'b0;
      recibir     <= '0;
      enviar      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
`ifdef CHEQUEO_TIMEOUT_EN
      r_wait      <= '0;
`endif
    end else begin
      timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_state <= RECIBIR;
            r_ptr   <= w_grant_idx;
            ch_sel  <= w_grant_idx;
            recibir <= w_grant_oh;
            busy    <= 1'b1;
          end
        end
        RECIBIR: begin
          r_state   <= SOLICITAR;
          recibir   <= '0;
          check_out <= 1'b1;
`ifdef CHEQUEO_TIMEOUT_EN
          r_wait    <= '0;
`endif
        end
        SOLICITAR: begin
          if (check_in) begin
            r_state <= ENVIAR;
            sel     <= 1'b1;
            enviar  <= w_sel_oh;
            r_burst <= '0;
          end else if (w_timeout) begin
            r_state     <= LIBERAR;
            check_out   <= 1'b0;
            timeout_err <= 1'b1;
          end
`ifdef CHEQUEO_TIMEOUT_EN
          else begin
            r_wait <= r_wait + CNT_W'(1);
          end
`endif
        end
        ENVIAR: begin
          // Grant loss ends the burst at once, even on its last beat
          if (!check_in || r_burst == CNT_W'(BURST_LEN - 1)) begin
            r_state   <= LIBERAR;
            check_out <= 1'b0;
            sel       <= 1'b0;
            enviar    <= '0;
          end else begin
            r_burst <= r_burst + CNT_W'(1);
          end
        end
        LIBERAR: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chequeo_dma_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_chequeo_dma_rr
// Brief    : Directed vector bench for chequeo_dma_rr (N_CH=4, BURST_LEN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chequeo_dma_rr;

  logic       clk;
  logic       rst_n;
  logic [3:0] estado_in;
  logic       check_in;
  logic       check_out;
  logic       sel;
  logic [1:0] ch_sel;
  logic [3:0] recibir;
  logic [3:0] enviar;
  logic       busy;
  logic       timeout_err;

  int n_vec;
  int n_err;

  chequeo_dma_rr #(.N_CH(4), .BURST_LEN(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .estado_in   (estado_in),
    .check_in    (check_in),
    .check_out   (check_out),
    .sel         (sel),
    .ch_sel      (ch_sel),
    .recibir     (recibir),
    .enviar      (enviar),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] est;
    logic       ci;
    logic       co;
    logic       sel;
    logic [1:0] chs;
    logic [3:0] rcv;
    logic [3:0] env;
    logic       busy;
  } vec_t;

  vec_t vt [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    estado_in = '0;
    check_in  = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Waits for the next RECIBIR strobe and checks which channel got it
  task automatic expect_serve(input int ch);
    int k;
    logic [3:0] oh;
    k  = 0;
    oh = 4'b0001 << ch;
    step();
    while (recibir == 4'b0000 && k < 40) begin
      step();
      k++;
    end
    chk($sformatf("serve_recibir_ch%0d", ch), 32'(recibir), 32'(oh));
    chk($sformatf("serve_ch_sel_ch%0d", ch), 32'(ch_sel), 32'(ch));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    //                est      ci    co    sel   chs   rcv      env      busy
    vt[0]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
    vt[1]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
    vt[2]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0100, 4'b0000, 1'b1};
    vt[3]  = '{4'b0100, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0000, 4'b0000, 1'b1};
    vt[4]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0100, 1'b1};
    vt[5]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0100, 1'b1};
    vt[6]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0100, 1'b1};
    vt[7]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0100, 1'b1};
    vt[8]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000, 1'b1};
    vt[9]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000, 1'b0};
    vt[10] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000, 1'b0};

    // Reset state
    do_reset();
    chk("reset_outputs",
        32'({check_out, sel, ch_sel, recibir, enviar, busy, timeout_err}), 32'd0);

    // Single request on ch2 with grant held high
    for (int i = 0; i < 11; i++) begin
      estado_in = vt[i].est;
      check_in  = vt[i].ci;
      step();
      chk($sformatf("vec[%0d]", i),
          32'({check_out, sel, ch_sel, recibir, enviar, busy, timeout_err}),
          32'({vt[i].co, vt[i].sel, vt[i].chs, vt[i].rcv, vt[i].env, vt[i].busy, 1'b0}));
    end

    // Simultaneous requests are served 0,1,2,3; a late ch1 rise is served next
    do_reset();
    check_in  = 1'b1;
    estado_in = 4'b1111;
    expect_serve(0);
    estado_in = 4'b1101;
    expect_serve(1);
    expect_serve(2);
    expect_serve(3);
    estado_in = 4'b1111;
    expect_serve(1);

    // Grant dropped after two beats on ch0 while ch1 waits
    do_reset();
    check_in  = 1'b1;
    estado_in = 4'b0011;
    expect_serve(0);
    step();
    step();
    chk("abort_beat1_enviar", 32'(enviar), 32'(4'b0001));
    step();
    chk("abort_beat2_enviar", 32'(enviar), 32'(4'b0001));
    check_in = 1'b0;
    step();
    chk("abort_release", 32'({enviar, sel, check_out, busy}), 32'({4'b0000, 1'b0, 1'b0, 1'b1}));
    check_in = 1'b1;
    expect_serve(1);
    expect_serve(0);

    // Grant never arrives
    do_reset();
    check_in  = 1'b0;
    estado_in = 4'b0010;
    expect_serve(1);
`ifdef CHEQUEO_TIMEOUT_EN
    begin
      int n_hi;
      n_hi = 0;
      step();
      while (check_out && n_hi < 100) begin
        n_hi++;
        step();
      end
      chk("timeout_check_out_cycles", 32'(n_hi), 32'd16);
      chk("timeout_err_pulse", 32'(timeout_err), 32'd1);
      step();
      chk("timeout_err_clear", 32'(timeout_err), 32'd0);
      expect_serve(1);
    end
`else
    repeat (40) step();
    chk("no_timeout_check_out", 32'({check_out, busy, timeout_err}), 32'({1'b1, 1'b1, 1'b0}));
`endif

    // Asynchronous reset in the middle of a burst
    do_reset();
    check_in  = 1'b1;
    estado_in = 4'b0001;
    expect_serve(0);
    step();
    step();
    chk("pre_reset_enviar", 32'(enviar), 32'(4'b0001));
    #2;
    rst_n     = 1'b0;
    estado_in = 4'b0000;
    #1;
    chk("async_reset_outputs",
        32'({check_out, sel, recibir, enviar, busy, timeout_err}), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("post_reset_idle", 32'({busy, check_out, recibir}), 32'd0);
    estado_in = 4'b1001;
    expect_serve(0);
    expect_serve(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/chequeo_dma_rr.md
# chequeo_dma_rr

Multi-channel bus-request controller for the DMA module. It collects transfer requests from N_CH I/O peripherals and serves them in round-robin order. For each served channel it runs the receive → bus-request → CPU-grant → send → release handshake. It sits between the I/O-side request lines and the processor's bus-grant interface, and drives the system-bus mux select and per-channel receive/send strobes. Compared with the single-channel checker, it adds parametrised channel count, burst length, grant-loss abort and an optional grant timeout.

## Interface
- N_CH, 4: number of I/O channels (2..16).
- BURST_LEN, 4: ENVIAR cycles per grant (1..255).
- TIMEOUT, 16: max SOLICITAR cycles before abort (1..255); used only with the timeout feature.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- estado_in  in  N_CH  per-channel "I/O has data" level; the rising edge is the request.
- check_in  in  1  processor bus grant.
- check_out  out  1  bus request to processor.
- sel  out  1  system-bus mux select, DMA side.
- ch_sel  out  $clog2(N_CH)  index of the channel being served.
- recibir  out  N_CH  one-hot receive strobe.
- enviar  out  N_CH  one-hot send strobe.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  one-cycle pulse on grant timeout.

## Operation
- Per-channel edge detect: `estado_q` is registered; `pend[i]` is set when `estado_in[i] & ~estado_q[i]`. `pend[i]` is cleared on entry to RECIBIR for channel i. If set and clear occur on the same cycle, set wins.
- Arbiter: `ptr` holds the last-served index and resets to N_CH-1. In IDLE, the channel chosen is the first pending one searching ptr+1, ptr+2, … with modulo-N_CH wrap. `ptr` is updated to the chosen channel on entry to RECIBIR.
- FSM states: IDLE, RECIBIR, SOLICITAR, ENVIAR, LIBERAR.
  - IDLE → RECIBIR if any `pend`; `ch_sel` is latched.
  - RECIBIR → SOLICITAR unconditionally (1 cycle).
  - SOLICITAR → ENVIAR when check_in=1 is sampled.
  - ENVIAR → LIBERAR after BURST_LEN cycles, or immediately if check_in is sampled 0 (grant loss).
  - LIBERAR → IDLE unconditionally (1 cycle).
- Abort: on grant loss, `pend[ch_sel]` is re-set, so the channel is re-queued behind the others.
- Output decoding is Moore, from registered state only:
  - RECIBIR: recibir[ch_sel]=1.
  - SOLICITAR: check_out=1.
  - ENVIAR: check_out=1, sel=1, enviar[ch_sel]=1.
  - All other states: these outputs are 0.
- Burst counter is 8-bit. It loads 0 on entry to ENVIAR; the exit condition is count==BURST_LEN-1.
- Reset values: state=IDLE, all outputs 0, ch_sel=0, pend=0, estado_q=0, ptr=N_CH-1. Reset asserted mid-transfer drops check_out/sel/enviar asynchronously, and pending requests are lost.

## Timing
- Request latency: estado_in rise sampled at edge k sets `pend` at k. RECIBIR is entered at k+1; check_out is high from k+2.
- Grant latency: check_in sampled high at edge g gives sel/enviar high from g to g+BURST_LEN. LIBERAR is one cycle, then IDLE.
- The minimum back-to-back service period per channel is BURST_LEN+4 cycles with an immediate grant.
- check_in is ignored outside SOLICITAR/ENVIAR.
- A request arriving during service waits in `pend`; it is never dropped.

## Configuration
- CHEQUEO_TIMEOUT_EN defined:
  - An 8-bit wait counter runs in SOLICITAR.
  - After TIMEOUT cycles without grant: SOLICITAR → LIBERAR, timeout_err pulses for 1 cycle in LIBERAR, and the channel is re-queued as on abort.
- Undefined: SOLICITAR waits indefinitely, and timeout_err is tied to 0.

## Structure
- Shared package `chequeo_pkg`: state enum (IDLE, RECIBIR, SOLICITAR, ENVIAR, LIBERAR) and the counter width constant CNT_W=8.
- One sub-module, `rr_arbiter`: parametrised by N_CH; inputs `pend` and `ptr`; outputs `grant_valid` and `grant_idx`. Purely combinational, instantiated once.

## Test plan
- N_CH=4, BURST_LEN=4: rise on ch2, check_in held 1. Expect recibir=0100 for 1 cycle, check_out 1 cycle earlier than sel, enviar=0100 for exactly 4 cycles, then LIBERAR, then busy=0.
- Simultaneous rises on ch0..ch3 after reset. Expect service order 0,1,2,3. Then a new rise on ch1 while ch3 is served: ch1 is served next.
- Grant dropped after 2 ENVIAR cycles on ch0 while ch1 is pending. Expect enviar cleared, ch1 served next, then ch0 re-served.
- With CHEQUEO_TIMEOUT_EN, TIMEOUT=16, check_in held 0. Expect check_out high 16 cycles, timeout_err 1-cycle pulse, channel re-queued. Without the macro: check_out stays high indefinitely.
- rst_n asserted mid-ENVIAR. Expect all outputs 0 asynchronously. After release: ptr=N_CH-1, no service until a new rising edge.
